// File: rtl/cplx_matmul_seq.sv
// Sequential N x N complex matrix multiplier: loads A and B beat by beat, runs one
// complex MAC per cycle (k innermost), then streams C row-major with valid/ready.
module cplx_matmul_seq #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [DW-1:0]           a_real,
  input  logic signed [DW-1:0]           a_imag,
  input  logic signed [DW-1:0]           b_real,
  input  logic signed [DW-1:0]           b_imag,
  input  logic                           conj_b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [2*DW+$clog2(N):0] result_real,
  output logic signed [2*DW+$clog2(N):0] result_imag,
  output logic                           out_last,
  output logic                           busy
);

  localparam int OW = 2*DW + 1 + $clog2(N);
  localparam int NN = N*N;
  localparam int KW = $clog2(N);
  localparam int IW = $clog2(NN);
  localparam logic [IW-1:0] LAST_IDX = IW'(NN-1);
  localparam logic [KW-1:0] LAST_K   = KW'(N-1);

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_OUTPUT} state_t;

  state_t                r_state, w_state_nxt;
  logic [IW-1:0]         r_ld_idx, r_out_idx;
  logic [KW-1:0]         r_i, r_j, r_k;
  logic                  r_conj;
  logic signed [OW-1:0]  r_acc_re, r_acc_im;

  logic signed [DW-1:0]  r_a_re [NN];
  logic signed [DW-1:0]  r_a_im [NN];
  logic signed [DW-1:0]  r_b_re [NN];
  logic signed [DW-1:0]  r_b_im [NN];
  logic signed [OW-1:0]  r_c_re [NN];
  logic signed [OW-1:0]  r_c_im [NN];

  logic [IW-1:0]         w_a_idx, w_b_idx, w_c_idx;
  logic                  w_i_last, w_j_last, w_k_last, w_mac_last;
  logic signed [DW-1:0]  w_ar, w_ai, w_br, w_bi;
  logic signed [2*DW-1:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;
  logic signed [OW-1:0]  w_term_re, w_term_im, w_sum_re, w_sum_im;

  function automatic logic signed [OW-1:0] sext(input logic signed [2*DW-1:0] v);
    return {{(OW-2*DW){v[2*DW-1]}}, v};
  endfunction

  assign w_a_idx    = IW'(r_i*N + r_k);
  assign w_b_idx    = IW'(r_k*N + r_j);
  assign w_c_idx    = IW'(r_i*N + r_j);
  assign w_i_last   = (r_i == LAST_K);
  assign w_j_last   = (r_j == LAST_K);
  assign w_k_last   = (r_k == LAST_K);
  assign w_mac_last = w_i_last && w_j_last && w_k_last;

  assign w_ar   = r_a_re[w_a_idx];
  assign w_ai   = r_a_im[w_a_idx];
  assign w_br   = r_b_re[w_b_idx];
  assign w_bi   = r_b_im[w_b_idx];
  assign w_p_rr = w_ar * w_br;
  assign w_p_ii = w_ai * w_bi;
  assign w_p_ri = w_ar * w_bi;
  assign w_p_ir = w_ai * w_br;

  // Conjugating B flips the sign of every bi term; done on products so -2^(DW-1) never overflows
  assign w_term_re = r_conj ? (sext(w_p_rr) + sext(w_p_ii)) : (sext(w_p_rr) - sext(w_p_ii));
  assign w_term_im = r_conj ? (sext(w_p_ir) - sext(w_p_ri)) : (sext(w_p_ir) + sext(w_p_ri));
  assign w_sum_re  = r_acc_re + w_term_re;
  assign w_sum_im  = r_acc_im + w_term_im;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_LOAD;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:    if (in_valid && r_ld_idx == LAST_IDX) w_state_nxt = S_COMPUTE;
      S_COMPUTE: if (w_mac_last) w_state_nxt = S_OUTPUT;
      S_OUTPUT:  if (out_ready && r_out_idx == LAST_IDX) w_state_nxt = S_LOAD;
      default:   w_state_nxt = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready    = (r_state == S_LOAD);
    busy        = (r_state == S_COMPUTE) || (r_state == S_OUTPUT);
    out_valid   = (r_state == S_OUTPUT);
    out_last    = (r_state == S_OUTPUT) && (r_out_idx == LAST_IDX);
    result_real = (r_state == S_OUTPUT) ? r_c_re[r_out_idx] : '0;
    result_imag = (r_state == S_OUTPUT) ? r_c_im[r_out_idx] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld_idx  <= '0;
      r_out_idx <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_conj    <= 1'b0;
      r_acc_re  <= '0;
      r_acc_im  <= '0;
    end else begin
      case (r_state)
        S_LOAD: if (in_valid) begin
          if (r_ld_idx == '0) r_conj <= conj_b;
          r_ld_idx <= (r_ld_idx == LAST_IDX) ? '0 : r_ld_idx + 1'b1;
        end
        S_COMPUTE: begin
          if (w_k_last) begin
            r_acc_re <= '0;
            r_acc_im <= '0;
            r_k      <= '0;
            if (w_j_last) begin
              r_j <= '0;
              r_i <= w_i_last ? '0 : r_i + 1'b1;
            end else begin
              r_j <= r_j + 1'b1;
            end
          end else begin
            r_acc_re <= w_sum_re;
            r_acc_im <= w_sum_im;
            r_k      <= r_k + 1'b1;
          end
        end
        S_OUTPUT: if (out_ready) r_out_idx <= (r_out_idx == LAST_IDX) ? '0 : r_out_idx + 1'b1;
        default: ;
      endcase
    end
  end

  // Matrix and result storage carry no reset; each load and compute pass overwrites all of it
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_LOAD && in_valid) begin
      r_a_re[r_ld_idx] <= a_real;
      r_a_im[r_ld_idx] <= a_imag;
      r_b_re[r_ld_idx] <= b_real;
      r_b_im[r_ld_idx] <= b_imag;
    end
    if (!rst && r_state == S_COMPUTE && w_k_last) begin
      r_c_re[w_c_idx] <= w_sum_re;
      r_c_im[w_c_idx] <= w_sum_im;
    end
  end

endmodule

// File: tb/tb_cplx_matmul_seq.sv
// Randomized self-checking bench for cplx_matmul_seq against a plain complex matrix model.
module tb_cplx_matmul_seq;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int OW = 2*DW + 1 + $clog2(N);
  localparam int NN = N*N;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, conj_b, out_valid, out_ready, out_last, busy;
  logic signed [DW-1:0] a_real, a_imag, b_real, b_imag;
  logic signed [OW-1:0] result_real, result_imag;

  int n_tests = 0;
  int n_fail  = 0;
  int ma_re[NN], ma_im[NN], mb_re[NN], mb_im[NN];
  int e_re[NN], e_im[NN];

  cplx_matmul_seq #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
    .conj_b(conj_b), .out_valid(out_valid), .out_ready(out_ready),
    .result_real(result_real), .result_imag(result_imag),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic ref_model(input bit cj);
    int sr, si, ar, ai, br, bi;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        sr = 0; si = 0;
        for (int k = 0; k < N; k++) begin
          ar = ma_re[i*N+k]; ai = ma_im[i*N+k];
          br = mb_re[k*N+j]; bi = cj ? -mb_im[k*N+j] : mb_im[k*N+j];
          sr += ar*br - ai*bi;
          si += ar*bi + ai*br;
        end
        e_re[i*N+j] = sr; e_im[i*N+j] = si;
      end
    end
  endtask

  task automatic fill_const(input int ar, input int ai, input int br, input int bi);
    for (int n = 0; n < NN; n++) begin
      ma_re[n] = ar; ma_im[n] = ai; mb_re[n] = br; mb_im[n] = bi;
    end
  endtask

  task automatic set_expected(input int re, input int im);
    for (int n = 0; n < NN; n++) begin e_re[n] = re; e_im[n] = im; end
  endtask

  task automatic do_load(input bit cj, input int nbeats, input bit gaps);
    int idx, guard;
    bit rdy;
    idx = 0; guard = 0;
    while (idx < nbeats && guard < 1000) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        a_real = DW'(ma_re[idx]); a_imag = DW'(ma_im[idx]);
        b_real = DW'(mb_re[idx]); b_imag = DW'(mb_im[idx]);
        conj_b = (idx == 0) ? cj : !cj;
      end
      rdy = in_ready;
      @(posedge clk); #1; guard++;
      if (in_valid) begin
        n_tests++;
        if (rdy !== 1'b1) begin
          n_fail++;
          $display("FAIL load_ready beat %0d: in_ready=%b, required 1", idx, rdy);
        end
        idx++;
      end
    end
    if (guard >= 1000) begin
      n_tests++; n_fail++;
      $display("FAIL load_timeout: %0d beats accepted, required %0d", idx, nbeats);
    end
    in_valid = 1'b0;
    a_real = DW'($urandom); b_imag = DW'($urandom);
  endtask

  task automatic collect(input bit bp, input int stall_at, input bit junk, output int lat);
    int idx, cyc, stall_cnt;
    bit rdy;
    idx = 0; cyc = 0; stall_cnt = 0;
    while (out_valid !== 1'b1 && cyc < 500) begin
      if (junk) begin
        in_valid  = 1'($urandom_range(0, 1));
        a_real    = DW'($urandom); a_imag = DW'($urandom);
        b_real    = DW'($urandom); b_imag = DW'($urandom);
        out_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1; cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    lat = cyc;
    if (cyc >= 500) begin
      n_tests++; n_fail++;
      $display("FAIL out_valid_timeout: out_valid=%b after %0d cycles, required 1", out_valid, cyc);
      return;
    end
    cyc = 0;
    while (idx < NN && cyc < 500) begin
      n_tests++;
      if (out_valid !== 1'b1 || int'(result_real) !== e_re[idx] || int'(result_imag) !== e_im[idx]
          || out_last !== (idx == NN-1)) begin
        n_fail++;
        $display("FAIL elem %0d: valid=%b re=%0d im=%0d last=%b, required valid=1 re=%0d im=%0d last=%b",
                 idx, out_valid, result_real, result_imag, out_last, e_re[idx], e_im[idx], idx == NN-1);
      end
      if (idx == stall_at && stall_cnt < 5) begin
        rdy = 1'b0; stall_cnt++;
      end else if (bp) begin
        rdy = ($urandom_range(0, 2) != 0);
      end else begin
        rdy = 1'b1;
      end
      out_ready = rdy;
      @(posedge clk); #1; cyc++;
      if (rdy) idx++;
    end
    out_ready = 1'b0;
    if (idx < NN) begin
      n_tests++; n_fail++;
      $display("FAIL stream_timeout: %0d elements taken, required %0d", idx, NN);
    end
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL return_to_load: out_valid=%b in_ready=%b busy=%b, required 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic check_idle(input string name);
    n_tests++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1
        || result_real !== '0 || result_imag !== '0) begin
      n_fail++;
      $display("FAIL %s: out_valid=%b out_last=%b busy=%b in_ready=%b re=%0d im=%0d, required 0 0 0 1 0 0",
               name, out_valid, out_last, busy, in_ready, result_real, result_imag);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; conj_b = 1'b1;
    a_real = 8'sd5; a_imag = 8'sd5; b_real = 8'sd5; b_imag = 8'sd5;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check_idle("reset_state");
    @(posedge clk); #1;
    check_idle("idle_after_reset");
  endtask

  task automatic test_const();
    int lat;
    fill_const(2, 3, 1, 2);
    set_expected(-16, 28);
    do_load(1'b0, NN, 1'b0);
    n_tests++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL compute_entry: busy=%b in_ready=%b out_valid=%b, required 1 0 0", busy, in_ready, out_valid);
    end
    collect(1'b0, -1, 1'b0, lat);
    n_tests++;
    if (lat != N*N*N) begin
      n_fail++;
      $display("FAIL compute_latency: %0d cycles, required %0d", lat, N*N*N);
    end
  endtask

  task automatic test_conj();
    int lat;
    fill_const(2, 3, 1, 2);
    set_expected(32, -4);
    do_load(1'b1, NN, 1'b1);
    collect(1'b0, -1, 1'b0, lat);
  endtask

  task automatic test_identity();
    int lat;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        ma_re[r*N+c] = (r == c) ? 1 : 0; ma_im[r*N+c] = 0;
        mb_re[r*N+c] = 4*r + c;          mb_im[r*N+c] = 4*r + c + 1;
        e_re[r*N+c]  = 4*r + c;          e_im[r*N+c]  = 4*r + c + 1;
      end
    end
    do_load(1'b0, NN, 1'b1);
    collect(1'b0, -1, 1'b1, lat);
  endtask

  task automatic test_extreme();
    int lat;
    fill_const(-128, -128, -128, -128);
    set_expected(0, 131072);
    do_load(1'b0, NN, 1'b0);
    collect(1'b0, -1, 1'b0, lat);
  endtask

  task automatic test_stall();
    int lat;
    fill_const(2, 3, 1, 2);
    for (int n = 0; n < NN; n++) begin mb_re[n] = n - 7; mb_im[n] = 3*n - 20; end
    ref_model(1'b0);
    do_load(1'b0, NN, 1'b0);
    collect(1'b0, 3, 1'b0, lat);
  endtask

  task automatic test_random();
    int lat;
    bit cj;
    for (int t = 0; t < 4; t++) begin
      for (int n = 0; n < NN; n++) begin
        ma_re[n] = int'($urandom_range(0, 255)) - 128; ma_im[n] = int'($urandom_range(0, 255)) - 128;
        mb_re[n] = int'($urandom_range(0, 255)) - 128; mb_im[n] = int'($urandom_range(0, 255)) - 128;
      end
      cj = 1'($urandom_range(0, 1));
      ref_model(cj);
      do_load(cj, NN, 1'b1);
      collect(1'b1, -1, 1'b1, lat);
    end
  endtask

  task automatic test_reset_abort();
    int lat, cyc;
    // mid-COMPUTE abort
    fill_const(2, 3, 1, 2);
    do_load(1'b1, NN, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check_idle("abort_compute");
    // mid-LOAD abort with junk, then clean REQ-037 load
    for (int n = 0; n < NN; n++) begin ma_re[n] = 9; mb_im[n] = -9; end
    do_load(1'b1, 5, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle("abort_load");
    fill_const(2, 3, 1, 2);
    set_expected(-16, 28);
    do_load(1'b0, NN, 1'b0);
    collect(1'b0, -1, 1'b0, lat);
    // mid-OUTPUT stall abort
    do_load(1'b0, NN, 1'b0);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 500) begin @(posedge clk); #1; cyc++; end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b0;
    check_idle("abort_output");
    do_load(1'b0, NN, 1'b1);
    collect(1'b1, -1, 1'b0, lat);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; conj_b = 1'b0;
    a_real = '0; a_imag = '0; b_real = '0; b_imag = '0;
    test_reset();
    test_const();
    test_conj();
    test_identity();
    test_extreme();
    test_stall();
    test_random();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cplx_matmul_seq.md
CPLX_MATMUL_SEQ -- requirements
Module: cplx_matmul_seq

Interface
REQ-001 The module SHALL have parameter N, default 4: matrix dimension, N >= 2.
REQ-002 The module SHALL have parameter DW, default 8: signed width of each real/imag input component.
REQ-003 The module SHALL have localparam OW = 2*DW + 1 + clog2(N): signed width of each output component.
REQ-004 Port clk, input, 1: the single clock; all logic SHALL be synchronous to its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port in_valid, input, 1: load beat valid.
REQ-007 Port in_ready, output, 1: load beat accepted when in_valid && in_ready.
REQ-008 Ports a_real and a_imag, input, DW each, signed: element of A.
REQ-009 Ports b_real and b_imag, input, DW each, signed: element of B, at the same (row, col) as A.
REQ-010 Port conj_b, input, 1: mode bit, sampled on the first accepted beat; 1 selects A*conj(B) (element-wise conjugate, no transpose).
REQ-011 Port out_valid, output, 1: result element valid.
REQ-012 Port out_ready, input, 1: downstream accepts the element when out_valid && out_ready.
REQ-013 Ports result_real and result_imag, output, OW each, signed: element C[i][j].
REQ-014 Port out_last, output, 1: high with the final element C[N-1][N-1].
REQ-015 Port busy, output, 1: high in COMPUTE or OUTPUT.

Function
REQ-016 The FSM SHALL have three states: LOAD, COMPUTE and OUTPUT; reset enters LOAD.
REQ-017 LOAD: in_ready = 1; each accepted beat writes A[r][c] and B[r][c] into internal storage, row-major, index 0..N*N-1.
REQ-018 When the N*N-th beat is accepted, the FSM SHALL enter COMPUTE on the next cycle; in_ready = 0 outside LOAD.
REQ-019 COMPUTE SHALL perform one complex MAC per cycle: acc += A[i][k]*B'[k][j], where B' = B, or conj(B) if conj_b was latched as 1.
REQ-020 The MAC loop order SHALL be k innermost, then j, then i; all N^3 terms are processed.
REQ-021 The complex product SHALL be computed as re = ar*br - ai*bi and im = ar*bi + ai*br, with full-precision signed arithmetic.
REQ-022 The accumulators SHALL be OW bits wide; no saturation and no rounding; overflow is impossible by construction.
REQ-023 Each completed C[i][j] (after k = N-1) SHALL be written to an N*N result buffer and its accumulator cleared.
REQ-024 COMPUTE SHALL last exactly N^3 cycles, then enter OUTPUT.
REQ-025 OUTPUT SHALL stream C row-major, one element per handshake, with out_valid held high.
REQ-026 While out_valid && !out_ready, result_real, result_imag and out_last SHALL be held stable.
REQ-027 out_last SHALL assert only on index N*N-1.
REQ-028 After that element is accepted, the FSM SHALL return to LOAD on the next cycle, with out_valid = 0 and in_ready = 1.
REQ-029 in_valid asserted outside LOAD SHALL be ignored (not stored, no side effects).
REQ-030 out_ready asserted outside OUTPUT SHALL be ignored.
REQ-031 An in_valid gap during LOAD SHALL stall the load index without error.
REQ-032 Storage contents need no reset; every matrix is fully overwritten on each load.

Reset
REQ-033 When rst = 1 at a clock edge, the block SHALL set state = LOAD, all indices and accumulators = 0, and latched conj_b = 0.
REQ-034 Outputs after reset SHALL be: out_valid = 0, out_last = 0, busy = 0, result_real = 0, result_imag = 0, and in_ready = 1 from the first cycle after rst deasserts.
REQ-035 rst in any state, including mid-LOAD, mid-COMPUTE or mid-OUTPUT stall, SHALL abort the operation; partial data SHALL never be emitted.
REQ-036 rst has priority over simultaneous in_valid and out_ready.

Verification
REQ-037 N=4, DW=8, A all 2+3i, B all 1+2i, conj_b=0 -> 16 outputs of -16+28i; out_last on the 16th; first out_valid 64 cycles after COMPUTE entry.
REQ-038 Same data with conj_b=1 -> 16 outputs of 32-4i.
REQ-039 A = identity (1+0i diagonal), B[r][c] = (4r+c) + (4r+c+1)i -> output equals B element-for-element, row-major.
REQ-040 A = B = all -128-128i -> every output is 0 + 131072i, with no wrap at OW=19.
REQ-041 out_ready low for 5 cycles at element 3 -> data stable, no element lost or duplicated; the stream resumes at element 3.
REQ-042 rst pulse at COMPUTE cycle 20 -> next cycle LOAD, busy=0, out_valid=0; a fresh load of the REQ-037 data then yields correct results.
